req_encoder: RTL and testbench
==============================

Name: req_encoder

Overview:
- Sequential companion to the 2-to-4 one-hot decoder: the encoder end of the same request/select interface.
- Collects one-hot request lines into a sticky pending register and encodes the highest-priority pending line (bit 0 highest, matching Y_0) into a binary index.
- Presents the index to a consumer over a valid/ready handshake and retires each request on acceptance.
- Its output feeds the decoder's A input, with E driven from out_valid.

Parameters:
- N, 4, number of request lines (N >= 2).
- W, 2, index width; must equal ceil(log2(N)).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  request capture / issue enable (decoder-style E)
- req  in  N  request pulses or levels; bit i requests index i
- out_idx  out  W  encoded index of the presented request
- out_valid  out  1  out_idx is valid
- out_ready  in  1  consumer accepts out_idx this cycle
- pend  out  N  current pending-request register
- any_pend  out  1  OR-reduction of pend (registered value)

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. While rst_n=0: pend=0, out_valid=0, out_idx=0, FSM=IDLE.
- Reset mid-transaction: the presented index and all pending requests are discarded. No handshake completes.
- Handshake: a handshake occurs on a rising edge where out_valid=1 and out_ready=1.
- clr mask: clr = onehot(out_idx) on a handshake, else 0.
- Pending update, every edge: pend <= (pend & ~clr) | (en ? req : 0).
- Set beats clear: a req bit asserted in the same cycle its index is retired re-pends that index.
- Merging: repeated req on an already-pending bit merges into a single request. There is no counting and no error.
- Priority: pri(x) = index of the lowest set bit of x. x=0 never loads.
- FSM has two states, IDLE and PRESENT:
  - IDLE: out_valid=0. If en=1 and pend!=0: out_idx<=pri(pend), out_valid<=1, go to PRESENT. Otherwise stay.
  - PRESENT: out_valid=1, and out_idx is held stable until a handshake. out_ready may be held low indefinitely.
  - PRESENT, on a handshake: let rem = pend & ~clr (registered pend only; req arriving this cycle is not included). If en=1 and rem!=0: out_idx<=pri(rem), stay in PRESENT, out_valid stays 1. This gives back-to-back issue, one per cycle. Otherwise out_valid<=0 and go to IDLE.
- Latency:
  - req sampled at edge k sets pend after edge k.
  - From IDLE, out_valid rises after edge k+1 (2-cycle latency).
  - With out_ready held 1, k pending requests drain in k consecutive cycles.
- Enable low:
  - New req is ignored.
  - Existing pend is retained.
  - A presentation already in PRESENT completes normally, but no further index is loaded afterwards.
  - Raising en resumes issue from the retained pend.
- Priority is not re-evaluated while presenting. A higher-priority request arriving during PRESENT waits for the current handshake.
- Outputs:
  - out_idx and out_valid are registered; no combinational path from req or out_ready.
  - pend and any_pend are registered.
  - any_pend reflects pend and excludes the currently presented index only after its handshake.
- Widths: out_idx is W bits. For N < 2^W, unused index values are never produced.

Test Plan:
1. Reset and idle: assert rst_n=0 mid-simulation with pend=4'b1010 and out_valid=1 -> immediately pend=0, out_valid=0, out_idx=0. Release rst_n with req=0 -> outputs stay at reset values.
2. Enable gating: with en=0, pulse req=4'b0100 for one cycle -> pend stays 0 and out_valid stays 0.
3. Single request latency: with en=1 and out_ready=1, pulse req=4'b0100 at edge k -> pend=4'b0100 after k. After k+1: out_idx=2, out_valid=1. After k+2: out_valid=0 and pend=0.
4. Priority and back-to-back drain: pulse req=4'b1011 with out_ready=1 -> out_idx sequence 0,1,3 on consecutive cycles with out_valid continuously 1, then out_valid=0 and pend=0.
5. Backpressure and set-beats-clear: present idx 1 with out_ready=0 for 5 cycles while req=4'b0001 arrives -> out_idx stays 1 throughout. Then assert out_ready=1 together with req=4'b0010 -> the next presentation is idx 0 and pend still holds bit 1, which re-presents afterwards.
6. en drop mid-stream: start with pend=4'b1100, presenting idx 2. Deassert en, then handshake -> out_valid=0 and pend=4'b1000 retained. Reassert en -> out_idx=3, out_valid=1.

Source files
------------

// File: rtl/req_encoder_if.sv
// Request/select bus between req_encoder and its consumer.
// Carries capture inputs, the issued index handshake and pending status.
interface req_encoder_if #(
    parameter int N = 4,
    parameter int W = 2
);
    logic         en;
    logic [N-1:0] req;
    logic [W-1:0] out_idx;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] pend;
    logic         any_pend;

    modport master (
        input  en,
        input  req,
        input  out_ready,
        output out_idx,
        output out_valid,
        output pend,
        output any_pend
    );

    modport slave (
        output en,
        output req,
        output out_ready,
        input  out_idx,
        input  out_valid,
        input  pend,
        input  any_pend
    );
endinterface

// File: rtl/req_encoder.sv
// Sticky one-hot request collector with lowest-index-first encoding.
// Issues indices over valid/ready; each handshake retires its request.
module req_encoder #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    req_encoder_if.master bus
);
    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t       state_q;
    state_t       state_nxt;
    logic [N-1:0] pend_q;
    logic [N-1:0] pend_nxt;
    logic [W-1:0] idx_q;
    logic [W-1:0] idx_nxt;
    logic         any_q;
    logic         hs;
    logic [N-1:0] clr;
    logic [N-1:0] rem;
    logic [N-1:0] set;

    function automatic logic [W-1:0] pri(input logic [N-1:0] x);
        logic [W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (x[i]) r = W'(i);
        end
        return r;
    endfunction

    assign hs  = (state_q == PRESENT) && bus.out_ready;
    assign clr = hs ? (N'(1) << idx_q) : '0;
    assign rem = pend_q & ~clr;
    // New requests are ORed in after the clear so a same-cycle set wins.
    assign set = bus.en ? bus.req : '0;
    assign pend_nxt = rem | set;

    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.en && (pend_q != '0)) begin
                    idx_nxt   = pri(pend_q);
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (hs) begin
                    if (bus.en && (rem != '0)) begin
                        idx_nxt = pri(rem);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            idx_q   <= '0;
            any_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            pend_q  <= pend_nxt;
            idx_q   <= idx_nxt;
            any_q   <= |pend_nxt;
        end
    end

    assign bus.out_idx   = idx_q;
    assign bus.out_valid = (state_q == PRESENT);
    assign bus.pend      = pend_q;
    assign bus.any_pend  = any_q;
endmodule

// File: tb/tb_req_encoder.sv
// Directed bench for req_encoder: reset, gating, latency, priority,
// backpressure with set-beats-clear, and enable drop mid-stream.
module tb_req_encoder;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    req_encoder_if #(.N(4), .W(2)) bus ();

    req_encoder #(.N(4), .W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.req = 4'b0000;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_pend", 32'(bus.pend), 32'h0);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_idx", 32'(bus.out_idx), 32'h0);
        chk("rst_any", 32'(bus.any_pend), 32'h0);
        rst_n = 1'b1;

        // 1: build pend=1010 with out_valid=1, then reset mid-transaction
        bus.en = 1'b1;
        bus.req = 4'b1010;
        step();
        bus.req = 4'b0000;
        chk("t1_pend", 32'(bus.pend), 32'ha);
        chk("t1_any", 32'(bus.any_pend), 32'h1);
        step();
        chk("t1_valid", 32'(bus.out_valid), 32'h1);
        chk("t1_idx", 32'(bus.out_idx), 32'h1);
        step();
        chk("t1_hold", 32'(bus.out_idx), 32'h1);
        rst_n = 1'b0;
        #2;
        chk("t1_rpend", 32'(bus.pend), 32'h0);
        chk("t1_rvalid", 32'(bus.out_valid), 32'h0);
        chk("t1_ridx", 32'(bus.out_idx), 32'h0);
        chk("t1_rany", 32'(bus.any_pend), 32'h0);
        rst_n = 1'b1;
        step();
        chk("t1_post_pend", 32'(bus.pend), 32'h0);
        chk("t1_post_valid", 32'(bus.out_valid), 32'h0);

        // 2: enable gating
        bus.en = 1'b0;
        bus.req = 4'b0100;
        step();
        bus.req = 4'b0000;
        chk("t2_pend", 32'(bus.pend), 32'h0);
        chk("t2_valid", 32'(bus.out_valid), 32'h0);
        step();
        chk("t2_valid2", 32'(bus.out_valid), 32'h0);

        // 3: single request latency
        bus.en = 1'b1;
        bus.out_ready = 1'b1;
        bus.req = 4'b0100;
        step();
        bus.req = 4'b0000;
        chk("t3_pend_k", 32'(bus.pend), 32'h4);
        chk("t3_valid_k", 32'(bus.out_valid), 32'h0);
        step();
        chk("t3_valid_k1", 32'(bus.out_valid), 32'h1);
        chk("t3_idx_k1", 32'(bus.out_idx), 32'h2);
        step();
        chk("t3_valid_k2", 32'(bus.out_valid), 32'h0);
        chk("t3_pend_k2", 32'(bus.pend), 32'h0);
        chk("t3_any_k2", 32'(bus.any_pend), 32'h0);

        // 4: priority and back-to-back drain
        bus.req = 4'b1011;
        step();
        bus.req = 4'b0000;
        chk("t4_pend", 32'(bus.pend), 32'hb);
        step();
        chk("t4_v0", 32'(bus.out_valid), 32'h1);
        chk("t4_i0", 32'(bus.out_idx), 32'h0);
        step();
        chk("t4_v1", 32'(bus.out_valid), 32'h1);
        chk("t4_i1", 32'(bus.out_idx), 32'h1);
        chk("t4_p1", 32'(bus.pend), 32'ha);
        step();
        chk("t4_v3", 32'(bus.out_valid), 32'h1);
        chk("t4_i3", 32'(bus.out_idx), 32'h3);
        chk("t4_p3", 32'(bus.pend), 32'h8);
        step();
        chk("t4_vend", 32'(bus.out_valid), 32'h0);
        chk("t4_pend_end", 32'(bus.pend), 32'h0);

        // 5: backpressure, then set-beats-clear
        bus.out_ready = 1'b0;
        bus.req = 4'b0010;
        step();
        bus.req = 4'b0000;
        step();
        chk("t5_idx", 32'(bus.out_idx), 32'h1);
        bus.req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_hold_idx", 32'(bus.out_idx), 32'h1);
            chk("t5_hold_valid", 32'(bus.out_valid), 32'h1);
        end
        chk("t5_pend_bp", 32'(bus.pend), 32'h3);
        bus.out_ready = 1'b1;
        bus.req = 4'b0010;
        step();
        bus.req = 4'b0000;
        chk("t5_next_idx", 32'(bus.out_idx), 32'h0);
        chk("t5_next_valid", 32'(bus.out_valid), 32'h1);
        chk("t5_repend", 32'(bus.pend), 32'h3);
        step();
        chk("t5_re_idx", 32'(bus.out_idx), 32'h1);
        chk("t5_re_valid", 32'(bus.out_valid), 32'h1);
        chk("t5_re_pend", 32'(bus.pend), 32'h2);
        step();
        chk("t5_end_valid", 32'(bus.out_valid), 32'h0);
        chk("t5_end_pend", 32'(bus.pend), 32'h0);

        // 6: en drop mid-stream
        bus.out_ready = 1'b0;
        bus.req = 4'b1100;
        step();
        bus.req = 4'b0000;
        step();
        chk("t6_idx", 32'(bus.out_idx), 32'h2);
        bus.en = 1'b0;
        step();
        chk("t6_hold", 32'(bus.out_idx), 32'h2);
        chk("t6_hold_v", 32'(bus.out_valid), 32'h1);
        bus.out_ready = 1'b1;
        step();
        chk("t6_off_valid", 32'(bus.out_valid), 32'h0);
        chk("t6_off_pend", 32'(bus.pend), 32'h8);
        step();
        chk("t6_keep_valid", 32'(bus.out_valid), 32'h0);
        chk("t6_keep_pend", 32'(bus.pend), 32'h8);
        chk("t6_keep_any", 32'(bus.any_pend), 32'h1);
        bus.en = 1'b1;
        step();
        chk("t6_res_idx", 32'(bus.out_idx), 32'h3);
        chk("t6_res_valid", 32'(bus.out_valid), 32'h1);
        step();
        chk("t6_fin_valid", 32'(bus.out_valid), 32'h0);
        chk("t6_fin_pend", 32'(bus.pend), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
